wb_stage: RTL

- Writeback stage between execute/memory and the register file.
- Registers the selected result (LUT, memory or ALU) and presents a single write port (`wb_wrt`, `wb_dst`, `wb_data`) to the register file.
- Tracks one outstanding variable-latency memory load and stalls upstream while it is pending.
- Forwards the in-flight writeback value to the register-read operands to resolve read-after-write hazards.

---
 rtl/wb_stage_pkg.sv | 11 +
 rtl/wb_stage_fwd_unit.sv | 28 ++
 rtl/wb_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, FSM states and result-source encoding for the writeback stage
package wb_stage_pkg;

    localparam int BYTE_W = 8;
    localparam int REG_AW = 3;

    typedef enum logic {IDLE, WAIT_MEM} wb_state_t;

    typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_LUT} wb_src_t;

endpackage

// File: rtl/wb_stage_fwd_unit.sv
// wb_fwd_unit: operand forwarding from the writeback port and pending-load hazard detection
module wb_fwd_unit #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          wb_wrt,
    input  logic [AW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    input  logic          wait_mem,
    input  logic [AW-1:0] pend,
    input  logic [AW-1:0] rd_ptrA,
    input  logic [AW-1:0] rd_ptrB,
    input  logic          rd_imdB,
    input  logic [DW-1:0] rf_rawA,
    input  logic [DW-1:0] rf_rawB,
    output logic [DW-1:0] fwd_A,
    output logic [DW-1:0] fwd_B,
    output logic          raw_hazard
);

    // an immediate B operand never reads the register file, so it neither forwards nor hazards
    always_comb begin
        fwd_A      = (wb_wrt && wb_dst == rd_ptrA) ? wb_data : rf_rawA;
        fwd_B      = (wb_wrt && !rd_imdB && wb_dst == rd_ptrB) ? wb_data : rf_rawB;
        raw_hazard = wait_mem && (rd_ptrA == pend || (!rd_imdB && rd_ptrB == pend));
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered writeback port with one outstanding memory load; watchdog under WB_WATCHDOG_EN
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW       = BYTE_W,
    parameter int AW       = REG_AW,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          init,
    input  logic          ex_valid,
    input  logic          ex_regWrt,
    input  logic          ex_lutLd,
    input  logic          ex_memLd,
    input  logic [AW-1:0] ex_dst,
    input  logic [DW-1:0] lut_data,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          ex_stall,
    output logic          wb_wrt,
    output logic [AW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_ptrA,
    input  logic [AW-1:0] rd_ptrB,
    input  logic          rd_imdB,
    input  logic [DW-1:0] rf_rawA,
    input  logic [DW-1:0] rf_rawB,
    output logic [DW-1:0] fwd_A,
    output logic [DW-1:0] fwd_B,
    output logic          raw_hazard,
    output logic          wd_err
);

    wb_state_t     state, state_nx;
    wb_src_t       src;
    logic          acc, timeout, wrt_nx;
    logic [AW-1:0] pend, pend_nx, dst_nx;
    logic [DW-1:0] data_nx;

    assign ex_stall = state == WAIT_MEM;

    // next state and next writeback values; a load whose data arrives with the request completes at once
    always_comb begin
        src      = ex_lutLd ? SRC_LUT : ex_memLd ? SRC_MEM : SRC_ALU;
        acc      = state == IDLE && ex_valid && ex_regWrt;
        state_nx = state;
        pend_nx  = pend;
        wrt_nx   = 1'b0;
        dst_nx   = wb_dst;
        data_nx  = wb_data;
        if (acc) begin
            dst_nx  = ex_dst;
            data_nx = src == SRC_LUT ? lut_data : src == SRC_ALU ? alu_data : mem_rdata;
            wrt_nx  = src != SRC_MEM || mem_rvalid;
            pend_nx = src == SRC_MEM ? ex_dst : pend;
            state_nx = (src == SRC_MEM && !mem_rvalid) ? WAIT_MEM : IDLE;
        end else if (state == WAIT_MEM && mem_rvalid) begin
            wrt_nx   = 1'b1;
            dst_nx   = pend;
            data_nx  = mem_rdata;
            state_nx = IDLE;
        end else if (timeout) begin
            state_nx = IDLE;
        end
    end

    // state and writeback port registers
    always_ff @(posedge clk) begin
        if (init) begin
            state   <= IDLE;
            pend    <= '0;
            wb_wrt  <= 1'b0;
            wb_dst  <= '0;
            wb_data <= '0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            wb_wrt  <= wrt_nx;
            wb_dst  <= dst_nx;
            wb_data <= data_nx;
        end
    end

`ifdef WB_WATCHDOG_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_q;

    assign timeout = state == WAIT_MEM && !mem_rvalid && wd_cnt == CW'(MAX_WAIT - 1);
    assign wd_err  = wd_q;

    // counter sits at zero while idle so every wait starts fresh; the error flag is sticky
    always_ff @(posedge clk) begin
        if (init) begin
            wd_cnt <= '0;
            wd_q   <= 1'b0;
        end else begin
            wd_cnt <= state == WAIT_MEM ? wd_cnt + 1'b1 : '0;
            wd_q   <= wd_q | timeout;
        end
    end
`else
    logic unused_max;

    assign timeout    = 1'b0;
    assign wd_err     = 1'b0;
    assign unused_max = ^MAX_WAIT;
`endif

    wb_fwd_unit #(.DW(DW), .AW(AW)) u_fwd (
        .wb_wrt     (wb_wrt),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .wait_mem   (ex_stall),
        .pend       (pend),
        .rd_ptrA    (rd_ptrA),
        .rd_ptrB    (rd_ptrB),
        .rd_imdB    (rd_imdB),
        .rf_rawA    (rf_rawA),
        .rf_rawB    (rf_rawB),
        .fwd_A      (fwd_A),
        .fwd_B      (fwd_B),
        .raw_hazard (raw_hazard)
    );

endmodule
